audio_gain_stage: RTL and testbench
===================================

AUDIO_GAIN_STAGE -- requirements
Module: audio_gain_stage

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- SAMPLE_W, 24, signed sample width per channel.
- GAIN_W, 8, unsigned gain width.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock; the only clock.
- arst_n, in, 1, reset; asynchronous, active-low.
- in_data, in, 2*SAMPLE_W, stereo frame: left in [47:24], right in [23:0].
- in_valid, in, 1, upstream frame valid (sine generator or DMA source).
- in_ready, out, 1, stage accepts a frame.
- out_data, out, 2*SAMPLE_W, scaled frame, same packing as in_data; feeds the sfifo write side.
- out_valid, out, 1, out_data valid (drives FIFO i_wr).
- out_ready, in, 1, downstream can accept (driven by !fifo_full).
- gain_l, in, GAIN_W, left gain, unsigned Q1.7; 0x80 = unity.
- gain_r, in, GAIN_W, right gain, unsigned Q1.7.
- mute, in, 1, forces the target gain of both channels to 0.

Function
REQ-003 A frame SHALL transfer on either side only in a cycle where valid and ready are both 1.
REQ-004 The stage SHALL be a 2-stage pipeline: S1 registers the product, S2 registers the saturated result. Each stage has a valid bit.
REQ-005 Advance enable en = out_ready | !S2_valid. Both stages SHALL move only when en=1. in_ready = en.
REQ-006 Latency SHALL be exactly 2 clk cycles from input acceptance to out_valid, with out_ready held 1. Throughput SHALL be one frame per cycle.
REQ-007 Per channel: product = signed sample × zero-extended gain (SAMPLE_W+GAIN_W+1 bits), then arithmetic shift right by 7 (floor, no rounding).
REQ-008 Saturation: results above 0x7FFFFF SHALL clamp to 0x7FFFFF; results below -0x800000 SHALL clamp to 0x800000.
REQ-009 Gain/mute sampling:
- The effective gain SHALL be sampled at input acceptance and travel with the frame.
- A gain change affects only frames accepted after it.
- Frames already in flight keep the gain they were accepted with.
REQ-010 mute=1 SHALL make the effective gain 0 for both channels, giving output 0x000000.
REQ-011 With out_ready=0 and S2 full:
- out_data and out_valid SHALL stay stable.
- No frame SHALL be lost, duplicated or reordered.
REQ-012 If a frame is accepted in the same cycle out_ready rises, S2 SHALL take S1's frame and S1 SHALL take the new frame.

Reset
REQ-013 While arst_n=0, all of the following SHALL hold:
- out_valid=0, S1_valid=0, out_data=0.
- Effective gain registers = 0.
- in_ready=0.
REQ-014 Asserting arst_n mid-stream SHALL discard in-flight frames; nothing SHALL be emitted afterwards from pre-reset frames.

Configuration
REQ-015 Macro VOLUME_RAMP_EN, when defined:
- Each channel SHALL hold an effective-gain register, reset to 0.
- On every accepted frame, the frame uses the current value.
- The register then steps by ±1 toward the target (gain input, or 0 if muted); it holds when equal.
REQ-016 Without VOLUME_RAMP_EN, the effective gain SHALL be the target, taken combinationally at acceptance, with no ramp registers.

Structure
REQ-017 Package audio_pkg SHALL hold SAMPLE_W, FRAME_W, GAIN_W, GAIN_UNITY (0x80), SAT_MAX and SAT_MIN.
REQ-018 Sub-module gain_channel (multiply, shift, saturate for one channel) SHALL be instantiated twice.

Verification
REQ-019 Unity gain: gain=0x80, in L=0x123456, R=0xFEDCBA -> identical frame out after 2 cycles (macro off).
REQ-020 Half gain: gain=0x40, L=0x000101 -> 0x000080; R=0xFFFFFF -> 0xFFFFFF (floor).
REQ-021 Saturation: gain=0xFF, L=0x7FFFFF -> 0x7FFFFF; R=0x800000 -> 0x800000.
REQ-022 Backpressure: stream 8 frames with counter data 1..8 and hold out_ready=0 for 10 cycles mid-stream -> in_ready drops after 2 frames are held, output is stable, and 1..8 arrive in order exactly once.
REQ-023 Mute: mute=1 set mid-stream -> frames accepted afterwards output 0x000000/0x000000; in-flight frames unchanged.
REQ-024 Ramp (VOLUME_RAMP_EN): after reset, gain=0x80, constant L=0x010000 -> frame k outputs k×0x200 for k=0..127, and 0x010000 from k=128 on.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants for the stereo audio gain stage
//
// Purpose : sample/gain widths, Q1.7 unity gain and the signed saturation
//           limits used by audio_gain_stage and gain_channel.
// Ports   : none (package).
// Config  : none; the optional ramp (VOLUME_RAMP_EN) lives in the top.

package audio_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int FRAME_W   = 2 * SAMPLE_W;
  localparam int GAIN_W    = 8;

  // Gain is unsigned Q1.7: 7 fractional bits, so 0x80 is 1.0.
  localparam int GAIN_FRAC = 7;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h80;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 24'sh7FFFFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 24'sh800000;

  // One-LSB step of a gain value toward a target; holds when equal.
  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt);
    logic [GAIN_W-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + GAIN_W'(1);
    end else if (cur > tgt) begin
      nxt = cur - GAIN_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gain_channel.sv
// rtl/gain_channel.sv - one channel: signed multiply, Q1.7 shift, saturate
//
// Purpose : two-register datapath for a single audio channel. The first
//           register holds the full-width product, the second holds the
//           floor-shifted and saturated sample.
// Ports   : clk, arst_n    - clock, asynchronous active-low reset
//           en             - pipeline advance; both registers move together
//           in_sample      - signed input sample
//           in_gain        - unsigned Q1.7 effective gain for this sample
//           out_sample     - saturated, scaled sample (second register)

module gain_channel
  import audio_pkg::GAIN_FRAC;
#(
  parameter int SAMPLE_W = 24,
  parameter int GAIN_W   = 8
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic        [GAIN_W-1:0]   in_gain,
  output logic signed [SAMPLE_W-1:0] out_sample
);

  // Sample times a zero-extended gain fits exactly in this width.
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  localparam logic signed [PROD_W-1:0] SAT_HI =
    {{(PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_LO =
    {{(PROD_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic signed [PROD_W-1:0]   samp_x;
  logic signed [PROD_W-1:0]   gain_x;
  logic signed [PROD_W-1:0]   shifted;
  logic signed [PROD_W-1:0]   prod_d, prod_q;
  logic signed [SAMPLE_W-1:0] sat_d,  sat_q;

  always_comb begin
    samp_x = PROD_W'(in_sample);                 // sign extension
    gain_x = PROD_W'({1'b0, in_gain});           // gain is never negative
    prod_d = prod_q;
    if (en) begin
      prod_d = samp_x * gain_x;
    end
  end

  // Arithmetic shift floors toward minus infinity (no rounding), so -1/2
  // comes out as -1.
  always_comb begin
    shifted = prod_q >>> GAIN_FRAC;
    sat_d   = sat_q;
    if (en) begin
      if (shifted > SAT_HI) begin
        sat_d = SAT_HI[SAMPLE_W-1:0];
      end else if (shifted < SAT_LO) begin
        sat_d = SAT_LO[SAMPLE_W-1:0];
      end else begin
        sat_d = shifted[SAMPLE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prod_q <= '0;
      sat_q  <= '0;
    end else begin
      prod_q <= prod_d;
      sat_q  <= sat_d;
    end
  end

  assign out_sample = sat_q;

endmodule

// File: rtl/audio_gain_stage.sv
// rtl/audio_gain_stage.sv - stereo two-stage gain pipeline with valid/ready
//
// Purpose : scales each channel of a stereo frame by an unsigned Q1.7 gain,
//           saturating to the sample range. Stage 1 holds the products,
//           stage 2 the saturated results. The gain in effect for a frame is
//           fixed at acceptance and travels with it.
// Ports   : clk, arst_n          - clock, asynchronous active-low reset
//           in_data/valid/ready  - input frame, left in the upper half
//           out_data/valid/ready - output frame, same packing
//           gain_l, gain_r       - target gains, 0x80 = unity
//           mute                 - forces both target gains to zero
// Config  : VOLUME_RAMP_EN - when defined, each channel keeps an effective
//           gain register (reset 0) that moves one LSB per accepted frame
//           toward its target; otherwise the target is used directly.

module audio_gain_stage
  import audio_pkg::gain_step;
#(
  parameter int SAMPLE_W = 24,
  parameter int GAIN_W   = 8
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [2*SAMPLE_W-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*SAMPLE_W-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [GAIN_W-1:0]       gain_l,
  input  logic [GAIN_W-1:0]       gain_r,
  input  logic                    mute
);

  logic en;
  logic accept;
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;

  logic [GAIN_W-1:0] tgt_l, tgt_r;
  logic [GAIN_W-1:0] eff_l, eff_r;

  logic signed [SAMPLE_W-1:0] out_l, out_r;

  // The whole pipe stalls only when the output register is full and
  // blocked; a bubble in S2 lets everything move.
  always_comb begin
    en       = out_ready | ~s2_valid_q;
    in_ready = en & arst_n;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    tgt_l = mute ? '0 : gain_l;
    tgt_r = mute ? '0 : gain_r;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (en) begin
      s1_valid_d = accept;
      s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

`ifdef VOLUME_RAMP_EN
  // The frame uses the register's current value; the register then moves
  // one step so the next accepted frame sees the updated gain.
  logic [GAIN_W-1:0] ramp_l_d, ramp_l_q;
  logic [GAIN_W-1:0] ramp_r_d, ramp_r_q;

  always_comb begin
    ramp_l_d = ramp_l_q;
    ramp_r_d = ramp_r_q;
    if (accept) begin
      ramp_l_d = gain_step(ramp_l_q, tgt_l);
      ramp_r_d = gain_step(ramp_r_q, tgt_r);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ramp_l_q <= '0;
      ramp_r_q <= '0;
    end else begin
      ramp_l_q <= ramp_l_d;
      ramp_r_q <= ramp_r_d;
    end
  end

  always_comb begin
    eff_l = ramp_l_q;
    eff_r = ramp_r_q;
  end
`else
  always_comb begin
    eff_l = tgt_l;
    eff_r = tgt_r;
  end
`endif

  gain_channel #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W)
  ) u_left (
    .clk        (clk),
    .arst_n     (arst_n),
    .en         (en),
    .in_sample  (in_data[2*SAMPLE_W-1:SAMPLE_W]),
    .in_gain    (eff_l),
    .out_sample (out_l)
  );

  gain_channel #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W)
  ) u_right (
    .clk        (clk),
    .arst_n     (arst_n),
    .en         (en),
    .in_sample  (in_data[SAMPLE_W-1:0]),
    .in_gain    (eff_r),
    .out_sample (out_r)
  );

  always_comb begin
    out_data  = {out_l, out_r};
    out_valid = s2_valid_q;
  end

endmodule

// File: tb/tb_audio_gain_stage.sv
// tb/tb_audio_gain_stage.sv - directed self-checking bench for audio_gain_stage

`timescale 1ns/1ps

module tb_audio_gain_stage;

  logic        clk;
  logic        arst_n;
  logic [47:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  gain_l;
  logic [7:0]  gain_r;
  logic        mute;

  int errors = 0;
  int checks = 0;

  logic [23:0] fl [256];
  logic [23:0] fr [256];
  logic [23:0] el [256];
  logic [23:0] er [256];

  audio_gain_stage #(.SAMPLE_W(24), .GAIN_W(8)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gain_l    (gain_l),
    .gain_r    (gain_r),
    .mute      (mute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single frame with out_ready=1: in S1 one cycle later, at the output the
  // cycle after that, gone once consumed.
  task automatic one(input string tag, input logic [23:0] l, input logic [23:0] r,
                     input logic [7:0] gl, input logic [7:0] gr, input logic m,
                     input logic [23:0] xl, input logic [23:0] xr);
    @(negedge clk);
    out_ready = 1'b1;
    gain_l    = gl;
    gain_r    = gr;
    mute      = m;
    in_data   = {l, r};
    in_valid  = 1'b1;
    #1 chk({tag, ".in_ready"}, 48'(in_ready), 48'd1);
    @(negedge clk);
    in_valid = 1'b0;
    mute     = 1'b0;
    chk({tag, ".lat1_valid"}, 48'(out_valid), 48'd0);
    @(negedge clk);
    chk({tag, ".lat2_valid"}, 48'(out_valid), 48'd1);
    chk({tag, ".data"}, out_data, {xl, xr});
    @(negedge clk);
    chk({tag, ".drained"}, 48'(out_valid), 48'd0);
  endtask

  // Streams n frames from fl/fr, expecting el/er in order. out_ready is low
  // for cycles [stall_lo, stall_hi); mute is raised from frame mute_at on.
  task automatic stream(input string tag, input int n, input int stall_lo,
                        input int stall_hi, input int mute_at);
    int tx  = 0;
    int rx  = 0;
    int cyc = 0;
    logic [47:0] held = '0;
    while (rx < n && cyc < 400) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      in_valid  = (tx < n);
      if (tx < n) in_data = {fl[tx], fr[tx]};
      mute = (tx >= mute_at);
      #1;
      if (cyc == stall_lo) held = out_data;
      if (cyc >= stall_lo && cyc < stall_hi) begin
        chk($sformatf("%s.stall_in_ready_c%0d", tag, cyc), 48'(in_ready), 48'd0);
        chk($sformatf("%s.stall_valid_c%0d", tag, cyc), 48'(out_valid), 48'd1);
        chk($sformatf("%s.stall_data_c%0d", tag, cyc), out_data, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s.frame%0d", tag, rx), out_data, {el[rx], er[rx]});
        rx++;
      end
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    chk({tag, ".count"}, 48'(rx), 48'(n));
    in_valid = 1'b0;
    mute     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".no_extra"}, 48'(out_valid), 48'd0);
  endtask

  initial begin
    arst_n    = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    gain_l    = 8'h80;
    gain_r    = 8'h80;
    mute      = 1'b0;

    #2;
    chk("reset.out_valid", 48'(out_valid), 48'd0);
    chk("reset.out_data", out_data, 48'd0);
    chk("reset.in_ready", 48'(in_ready), 48'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;

`ifdef VOLUME_RAMP_EN
    for (int k = 0; k < 132; k++) begin
      fl[k] = 24'h010000;
      fr[k] = 24'h010000;
      el[k] = (k < 128) ? 24'(k * 24'h200) : 24'h010000;
      er[k] = el[k];
    end
    stream("ramp", 132, -1, -1, 1000);
`else
    one("unity", 24'h123456, 24'hFEDCBA, 8'h80, 8'h80, 1'b0, 24'h123456, 24'hFEDCBA);
    one("half",  24'h000101, 24'hFFFFFF, 8'h40, 8'h40, 1'b0, 24'h000080, 24'hFFFFFF);
    one("sat",   24'h7FFFFF, 24'h800000, 8'hFF, 8'hFF, 1'b0, 24'h7FFFFF, 24'h800000);
    one("split", 24'h000010, 24'h000100, 8'h80, 8'h40, 1'b0, 24'h000010, 24'h000080);
    one("zero",  24'h123456, 24'h654321, 8'h00, 8'h00, 1'b0, 24'h000000, 24'h000000);
    one("mute1", 24'h123456, 24'hFEDCBA, 8'h80, 8'h80, 1'b1, 24'h000000, 24'h000000);
    // 0xFFFF00 = -256; -256 * 0xC0 / 128 = -384 = 0xFFFE80
    one("neg",   24'hFFFF00, 24'h000100, 8'hC0, 8'hC0, 1'b0, 24'hFFFE80, 24'h000180);

    gain_l = 8'h80;
    gain_r = 8'h80;
    for (int k = 0; k < 8; k++) begin
      fl[k] = 24'(k + 1);
      fr[k] = 24'(k + 1);
      el[k] = 24'(k + 1);
      er[k] = 24'(k + 1);
    end
    stream("bp", 8, 4, 14, 1000);

    for (int k = 0; k < 6; k++) begin
      fl[k] = 24'h000100;
      fr[k] = 24'h000100;
      el[k] = (k < 2) ? 24'h000100 : 24'h000000;
      er[k] = el[k];
    end
    stream("mute", 6, -1, -1, 2);
`endif

    @(negedge clk);
    out_ready = 1'b1;
    gain_l    = 8'h80;
    gain_r    = 8'h80;
    in_data   = {24'h111111, 24'h222222};
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 48'(out_valid), 48'd0);
    chk("midrst.in_ready", 48'(in_ready), 48'd0);
    chk("midrst.out_data", out_data, 48'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst.after%0d", k), 48'(out_valid), 48'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
